// File: rtl/prob_bist_pkg.sv
// prob_bist_pkg -- shared types and constants for the probabilistic BIST controller.
//   state_t : controller states (IDLE, APPLY, SAMPLE, DONE)
//   vec_t   : 4-bit stimulus vector {A,B,C,D}
//   resp_t  : 3-bit response {Out_1,Out_2,Out_3}
package prob_bist_pkg;

  localparam int N_VEC    = 16;
  localparam int RESP_W   = 3;
  localparam int VEC_W    = 4;
  localparam int ERR_W    = 5;
  localparam int SETTLE_W = 4;
  localparam int TABLE_W  = N_VEC * RESP_W;

  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [RESP_W-1:0] resp_t;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/prob_bist_cmp.sv
// prob_bist_cmp -- golden-table lookup and response compare.
// Ports:
//   vec      in  4b : vector currently applied to the unit under test
//   resp     in  3b : response returned by the unit under test
//   mismatch out 1b : high when resp differs from the golden entry for vec
// Purely combinational; the controller only uses mismatch to update registers.
module prob_bist_cmp
  import prob_bist_pkg::*;
#(
  parameter logic [47:0] EXP_TABLE = 48'h0
) (
  input  logic [3:0] vec,
  input  logic [2:0] resp,
  output logic       mismatch
);

  resp_t expected;

  assign expected = EXP_TABLE[RESP_W*vec +: RESP_W];
  assign mismatch = (resp != expected);

endmodule

// File: rtl/prob_bist_ctrl.sv
// prob_bist_ctrl -- exhaustive 16-vector BIST sweep of a 4-input, 3-output
// combinational unit, compared against a golden response table.
// Ports:
//   clk       in  1b : rising-edge clock
//   rst       in  1b : asynchronous active-high reset
//   start     in  1b : one-cycle request to run a sweep (ignored while busy)
//   dut_out   in  3b : {Out_1,Out_2,Out_3} from the unit under test
//   dut_in    out 4b : {A,B,C,D} to the unit under test, A is the MSB
//   busy      out 1b : sweep in progress
//   done      out 1b : sweep completed
//   pass      out 1b : valid with done, high when no vector mismatched
//   fail_vec  out 4b : first mismatching vector of the sweep
//   err_count out 5b : number of mismatching vectors, saturating at 31
// Configuration macro: BIST_ERRCNT_EN enables the error counter. When it is
// undefined err_count reads 0 and pass comes from a 1-bit sticky mismatch flag.
module prob_bist_ctrl
  import prob_bist_pkg::*;
#(
  parameter int          SETTLE_CYC = 1,
  parameter logic [47:0] EXP_TABLE  = 48'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] dut_out,
  output logic [3:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [4:0] err_count
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam vec_t                LAST_VEC    = VEC_W'(N_VEC - 1);

  state_t              state;
  vec_t                vec;
  logic [SETTLE_W-1:0] settle;
  logic                mismatch;
  logic                clean;   // no mismatch recorded so far in this sweep

  prob_bist_cmp #(
    .EXP_TABLE (EXP_TABLE)
  ) u_cmp (
    .vec      (vec),
    .resp     (dut_out),
    .mismatch (mismatch)
  );

  // The vector register drives the unit directly: 0 in IDLE, holds 15 in DONE.
  assign dut_in = vec;

`ifdef BIST_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;
  assign clean     = (err_cnt == '0);
  assign err_count = err_cnt;
`else
  logic seen_err;
  assign clean     = !seen_err;
  assign err_count = '0;
`endif

  // NOTE: all state updates use non-blocking assignments and the reset is in
  // the sensitivity list, so rst clears every register without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      settle   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= '0;
`ifdef BIST_ERRCNT_EN
      err_cnt  <= '0;
`else
      seen_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= APPLY;
            vec      <= '0;
            settle   <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= '0;
`ifdef BIST_ERRCNT_EN
            err_cnt  <= '0;
`else
            seen_err <= 1'b0;
`endif
          end else if (state == DONE) begin
            // done/pass are published one cycle after entering DONE, once the
            // last SAMPLE update has landed; this gives the 16*(S+1)+1 latency.
            done <= 1'b1;
            pass <= clean;
          end
        end

        APPLY: begin
          if (settle == SETTLE_LAST) begin
            settle <= '0;
            state  <= SAMPLE;
          end else begin
            settle <= settle + 1'b1;
          end
        end

        SAMPLE: begin
          if (mismatch) begin
            // clean still reflects the count before this vector.
            if (clean) fail_vec <= vec;
`ifdef BIST_ERRCNT_EN
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
`else
            seen_err <= 1'b1;
`endif
          end
          if (vec == LAST_VEC) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            vec   <= vec + 1'b1;
            state <= APPLY;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
